as512512512_spi_ctrl: RTL and testbench
=======================================

AS512512512_SPI_CTRL -- requirements
Module: as512512512_spi_ctrl

Interface
REQ-001 Parameter CS_GAP, default 4: minimum cs_n-high cycles between transactions (1..15).
REQ-002 clk  in  1  rising-edge clock for all logic.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 divisor  in  8  SCLK divisor, passed unmodified to eng_divisor.
REQ-005 a_req / b_req  in  1  requester A/B transaction request; level, sampled only in IDLE.
REQ-006 a_len / b_len  in  4  byte count minus one (0 = 1 byte, 15 = 16 bytes); sampled at grant.
REQ-007 a_tx_data / b_tx_data  in  8  next byte to transmit; must be valid while gnt=1 and until tx_ack.
REQ-008 a_gnt / b_gnt  out  1  requester owns the bus; high from grant until the done pulse, inclusive.
REQ-009 a_tx_ack / b_tx_ack  out  1  one-cycle pulse: tx_data byte consumed; requester presents the next byte by the following cycle.
REQ-010 a_rx_data / b_rx_data  out  8  received byte; valid while rx_valid=1.
REQ-011 a_rx_valid / b_rx_valid  out  1  one-cycle pulse per received byte.
REQ-012 a_done / b_done  out  1  one-cycle pulse: transaction complete.
REQ-013 cs_n  out  1  chip select, active-low.
REQ-014 eng_divisor  out  8, eng_din  out  8, eng_start  out  1: byte-engine controls.
REQ-015 eng_busy  in  1, eng_dout  in  8: byte-engine status and received byte.

Function
REQ-016 States: IDLE, SETUP, LOAD, ARM, WAIT, NEXT, GAP.
REQ-017 IDLE: if any req is high, grant by round-robin, latch len into a 4-bit remaining counter, drive cs_n low, go to SETUP.
REQ-018 Round-robin: on a tie, grant the requester not granted last; after reset, A wins the first tie; a single requester is always granted.
REQ-019 SETUP: one cycle with cs_n low and no start, then LOAD.
REQ-020 LOAD: eng_din = granted tx_data, eng_start = 1 for exactly one cycle, tx_ack pulses in the same cycle, go to ARM.
REQ-021 ARM: 2 cycles with eng_busy ignored, covering the engine's 2-cycle busy-assert latency; then WAIT.
REQ-022 WAIT: hold until eng_busy = 0; in that cycle, register eng_dout into rx_data, go to NEXT.
REQ-023 NEXT: rx_valid pulses; if remaining = 0, pulse done, drop gnt, drive cs_n high, go to GAP; else decrement remaining and go to LOAD.
REQ-024 GAP: hold cs_n high for CS_GAP cycles counted from the done cycle, then IDLE; a request held during GAP is granted on IDLE entry.
REQ-025 Only the granted requester's gnt/tx_ack/rx_valid/done/rx_data may toggle; the other port's outputs stay 0.
REQ-026 Dropping req mid-transaction is ignored; exactly len+1 bytes always transfer.
REQ-027 cs_n is low continuously from SETUP through NEXT; never toggles between bytes.
REQ-028 Per-byte latency from LOAD to rx_valid = 1 + 2 + (engine busy time) + 1 cycles.

Reset
REQ-029 rst_n = 0 at a clock edge: state = IDLE, cs_n = 1, eng_start = 0, eng_din = 0, all gnt/tx_ack/rx_valid/done = 0, rx_data = 0, remaining = 0, round-robin pointer = favour A.
REQ-030 Reset mid-transaction aborts with no done pulse; cs_n rises on the reset edge.

Configuration
REQ-031 With AS512512512_SPI_CS_GAP_EN defined: GAP state present, behaving per REQ-024.
REQ-032 Without AS512512512_SPI_CS_GAP_EN: GAP is omitted; NEXT on the last byte returns directly to IDLE with cs_n high; CS_GAP is unused.

Structure
REQ-033 Package as512512512_spi_pkg holds the state enum, the ARM_CYCLES = 2 constant and the default CS_GAP.
REQ-034 Round-robin grant logic is a sub-module, as512512512_spi_rr_arb (2 requests, 1-hot grant, pointer updates on grant).

Verification
REQ-035 A only, a_len = 0, tx 0xA5, engine loopback: one eng_start with din = 0xA5 -> a_rx_data = 0xA5, one a_rx_valid, a_done; cs_n low for the whole byte.
REQ-036 B, b_len = 3, bytes 0x01..0x04: 4 tx_ack, 4 rx_valid in order, one done, 4 eng_start pulses, cs_n never high between bytes.
REQ-037 a_req and b_req raised the same cycle after reset: A granted first, then B; next tie goes to A again only if B was last granted.
REQ-038 rst_n low during byte 2 of a 4-byte transaction -> cs_n = 1 on the next edge, no done pulse, next request restarts from SETUP.
REQ-039 Macro defined, CS_GAP = 4, b_req held during A's transaction -> cs_n high for 4 cycles before b_gnt; macro undefined -> b_gnt on IDLE entry.
REQ-040 eng_busy held high for 200 cycles (divisor = 99) -> controller stays in WAIT, no extra eng_start, rx_valid only after busy falls.

Source files
------------

// File: rtl/as512512512_spi_pkg.sv
// Shared types and constants for the dual-requester SPI transaction controller.
// Holds the controller state enum, the engine busy-assert latency and the
// default chip-select gap.
package as512512512_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    ARM,
    WAIT,
    NEXT,
    GAP
  } state_e;

  // Cycles after eng_start before the engine's busy flag can be trusted.
  localparam int ARM_CYCLES     = 2;
  localparam int CS_GAP_DEFAULT = 4;

endpackage

// File: rtl/as512512512_spi_if.sv
// One requester port of the SPI controller.
//   master : requester side (drives req/len/tx_data)
//   slave  : controller side (drives gnt/tx_ack/rx_data/rx_valid/done)
interface as512512512_spi_if;
  logic       req;
  logic [3:0] len;
  logic [7:0] tx_data;
  logic       gnt;
  logic       tx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       done;

  modport master (
    output req, len, tx_data,
    input  gnt, tx_ack, rx_data, rx_valid, done
  );

  modport slave (
    input  req, len, tx_data,
    output gnt, tx_ack, rx_data, rx_valid, done
  );
endinterface

// File: rtl/as512512512_spi_rr_arb.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : arbitration window (controller idle)
//   req[1:0]   : requests, bit 0 = A, bit 1 = B
//   gnt[1:0]   : one-hot grant, combinational, only while en
// The pointer moves on every grant so a tie goes to whoever was not granted
// last; out of reset A wins the first tie.
module as512512512_spi_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic fav_b;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt = fav_b ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    fav_b <= 1'b0;
    else if (|gnt) fav_b <= gnt[0];
  end

endmodule

// File: rtl/as512512512_spi_ctrl.sv
// SPI transaction controller: arbitrates two requesters onto one byte engine
// and sequences a multi-byte transfer under a single continuous cs_n low.
//   clk, rst_n         : clock, synchronous active-low reset
//   divisor            : SCLK divisor, passed straight to eng_divisor
//   a, b               : requester ports (slave modport)
//   cs_n               : chip select, active-low
//   eng_divisor/eng_din/eng_start : byte-engine controls
//   eng_busy/eng_dout  : byte-engine status and received byte
// Build option: define AS512512512_SPI_CS_GAP_EN to enforce a minimum cs_n-high
// gap of CS_GAP cycles between transactions; otherwise the last byte returns
// straight to IDLE.
module as512512512_spi_ctrl
  import as512512512_spi_pkg::*;
#(
  parameter int CS_GAP = CS_GAP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] divisor,
  as512512512_spi_if.slave a,
  as512512512_spi_if.slave b,
  output logic       cs_n,
  output logic [7:0] eng_divisor,
  output logic [7:0] eng_din,
  output logic       eng_start,
  input  logic       eng_busy,
  input  logic [7:0] eng_dout
);

  localparam logic [1:0] ARM_LOAD = 2'(ARM_CYCLES - 1);

  state_e     state, nxt;
  logic [1:0] own;       // owner of the current/last transaction, bit 0 = A
  logic [1:0] gnt_arb;
  logic [3:0] rem;
  logic [1:0] arm_cnt;
  logic [7:0] rx_q;
  logic       active;
  logic       last;

  as512512512_spi_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req   ({b.req, a.req}),
    .gnt   (gnt_arb)
  );

`ifdef AS512512512_SPI_CS_GAP_EN
  // cs_n is high for the GAP cycles plus the IDLE cycle that grants, so GAP
  // itself lasts CS_GAP-1 cycles and the total high time is CS_GAP.
  localparam logic [3:0] GAP_LOAD = 4'(CS_GAP - 1);
  logic [3:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)              gap_cnt <= '0;
    else if (state == NEXT)  gap_cnt <= GAP_LOAD;
    else if (state == GAP)   gap_cnt <= gap_cnt - 4'd1;
  end
`else
  logic unused_cs_gap;
  assign unused_cs_gap = (CS_GAP == 0);
`endif

  assign last = (rem == 4'd0);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (|gnt_arb) nxt = SETUP;
      SETUP: nxt = LOAD;
      LOAD:  nxt = ARM;
      ARM:   if (arm_cnt == 2'd0) nxt = WAIT;
      WAIT:  if (!eng_busy) nxt = NEXT;
      NEXT: begin
        if (!last) nxt = LOAD;
        else begin
`ifdef AS512512512_SPI_CS_GAP_EN
          nxt = (CS_GAP > 1) ? GAP : IDLE;
`else
          nxt = IDLE;
`endif
        end
      end
      GAP: begin
`ifdef AS512512512_SPI_CS_GAP_EN
        if (gap_cnt <= 4'd1) nxt = IDLE;
`else
        nxt = IDLE;
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      own     <= '0;
      rem     <= '0;
      arm_cnt <= '0;
      rx_q    <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (|gnt_arb) begin
          own <= gnt_arb;
          rem <= gnt_arb[1] ? b.len : a.len;
        end
        LOAD: arm_cnt <= ARM_LOAD;
        ARM:  if (arm_cnt != 2'd0) arm_cnt <= arm_cnt - 2'd1;
        WAIT: if (!eng_busy) rx_q <= eng_dout;
        NEXT: if (!last) rem <= rem - 4'd1;
        default: ;
      endcase
    end
  end

  // All strobes decode from state, so a reset edge drops them (and raises
  // cs_n) immediately with no done pulse.
  assign active      = state inside {SETUP, LOAD, ARM, WAIT, NEXT};
  assign cs_n        = !active;
  assign eng_start   = (state == LOAD);
  assign eng_din     = eng_start ? (own[1] ? b.tx_data : a.tx_data) : 8'h00;
  assign eng_divisor = divisor;

  assign a.gnt      = own[0] & active;
  assign a.tx_ack   = own[0] & eng_start;
  assign a.rx_valid = own[0] & (state == NEXT);
  assign a.done     = a.rx_valid & last;
  assign a.rx_data  = own[0] ? rx_q : 8'h00;

  assign b.gnt      = own[1] & active;
  assign b.tx_ack   = own[1] & eng_start;
  assign b.rx_valid = own[1] & (state == NEXT);
  assign b.done     = b.rx_valid & last;
  assign b.rx_data  = own[1] ? rx_q : 8'h00;

endmodule

// File: tb/tb_as512512512_spi_ctrl.sv
// Directed self-checking bench for as512512512_spi_ctrl with a loopback byte
// engine model (busy rises 2 cycles after start, lasts busy_len cycles).
module tb_as512512512_spi_ctrl;

  localparam int CS_GAP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] divisor = 8'd4;
  logic       cs_n;
  logic [7:0] eng_divisor, eng_din, eng_dout;
  logic       eng_start, eng_busy;

  as512512512_spi_if ia ();
  as512512512_spi_if ib ();

  as512512512_spi_ctrl #(.CS_GAP(CS_GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .divisor     (divisor),
    .a           (ia),
    .b           (ib),
    .cs_n        (cs_n),
    .eng_divisor (eng_divisor),
    .eng_din     (eng_din),
    .eng_start   (eng_start),
    .eng_busy    (eng_busy),
    .eng_dout    (eng_dout)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- byte engine model (loopback) ----------------
  int         busy_len = 3;
  logic [1:0] dly = '0;
  logic [8:0] bcnt = '0;
  logic [7:0] lat = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      dly <= '0; bcnt <= '0; lat <= '0;
    end else begin
      if (eng_start) begin
        lat <= eng_din;
        dly <= 2'd2;
      end else if (dly != 2'd0) begin
        dly <= dly - 2'd1;
        if (dly == 2'd1) bcnt <= 9'(busy_len);
      end
      if (bcnt != 9'd0) bcnt <= bcnt - 9'd1;
    end
  end
  assign eng_busy = (bcnt != 9'd0);
  assign eng_dout = lat;

  // ---------------- requester data model ----------------
  logic       clr = 1'b0;
  logic [7:0] a_bytes [16];
  logic [7:0] b_bytes [16];
  logic [3:0] a_idx = '0, b_idx = '0;

  always @(posedge clk) begin
    if (clr) begin
      a_idx <= '0; b_idx <= '0;
    end else begin
      if (ia.tx_ack) a_idx <= a_idx + 4'd1;
      if (ib.tx_ack) b_idx <= b_idx + 4'd1;
    end
  end
  assign ia.tx_data = a_bytes[a_idx];
  assign ib.tx_data = b_bytes[b_idx];

  // ---------------- monitor ----------------
  int cyc = 0, ack_cyc = 0, lat_last = 0;
  int n_start = 0, a_ack = 0, a_rxv = 0, a_done = 0, b_ack = 0, b_rxv = 0, b_done = 0;
  int cs_bad = 0, xtalk = 0, busy_rxv = 0;
  logic [7:0] st_din [$];
  logic [7:0] a_rx [$];
  logic [7:0] b_rx [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      n_start <= 0; a_ack <= 0; a_rxv <= 0; a_done <= 0;
      b_ack <= 0; b_rxv <= 0; b_done <= 0;
      cs_bad <= 0; xtalk <= 0; busy_rxv <= 0; lat_last <= 0;
      st_din.delete(); a_rx.delete(); b_rx.delete();
    end else begin
      if (eng_start) begin
        n_start <= n_start + 1;
        st_din.push_back(eng_din);
        ack_cyc <= cyc;
      end
      if (ia.tx_ack) a_ack <= a_ack + 1;
      if (ib.tx_ack) b_ack <= b_ack + 1;
      if (ia.rx_valid) begin
        a_rxv <= a_rxv + 1; a_rx.push_back(ia.rx_data); lat_last <= cyc - ack_cyc;
      end
      if (ib.rx_valid) begin
        b_rxv <= b_rxv + 1; b_rx.push_back(ib.rx_data); lat_last <= cyc - ack_cyc;
      end
      if (ia.done) a_done <= a_done + 1;
      if (ib.done) b_done <= b_done + 1;
      if ((ia.gnt || ib.gnt) && cs_n) cs_bad <= cs_bad + 1;
      if (ib.gnt && |{ia.gnt, ia.tx_ack, ia.rx_valid, ia.done, ia.rx_data}) xtalk <= xtalk + 1;
      if (ia.gnt && |{ib.gnt, ib.tx_ack, ib.rx_valid, ib.done, ib.rx_data}) xtalk <= xtalk + 1;
      if ((ia.rx_valid || ib.rx_valid) && eng_busy) busy_rxv <= busy_rxv + 1;
    end
  end

  function automatic logic [7:0] qat(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    clr = 1'b0;
  endtask

  // Bounded wait; the caller judges the outcome.
  task automatic wait_for(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      case (sel)
        0: ok = ia.done;
        1: ok = ib.done;
        2: ok = ia.gnt;
        3: ok = ib.gnt;
        4: ok = ia.gnt | ib.gnt;
        5: ok = (a_ack >= 2);
        6: ok = !cs_n;
        default: ok = 1'b1;
      endcase
      if (ok) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    nvec++; if (cs_n !== 1'b1) begin nerr++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    nvec++; if ({eng_start, eng_din} !== 9'h0) begin nerr++; $display("FAIL reset_eng: got %h want 000", {eng_start, eng_din}); end
    nvec++; if ({ia.gnt, ia.tx_ack, ia.rx_valid, ia.done, ia.rx_data} !== 12'h0) begin
      nerr++; $display("FAIL reset_a_out: got %h want 000", {ia.gnt, ia.tx_ack, ia.rx_valid, ia.done, ia.rx_data}); end
    nvec++; if ({ib.gnt, ib.tx_ack, ib.rx_valid, ib.done, ib.rx_data} !== 12'h0) begin
      nerr++; $display("FAIL reset_b_out: got %h want 000", {ib.gnt, ib.tx_ack, ib.rx_valid, ib.done, ib.rx_data}); end
    nvec++; if (eng_divisor !== 8'd4) begin nerr++; $display("FAIL reset_divisor: got %0d want 4", eng_divisor); end
    rst_n = 1'b1;
    do_clr();
    tick();
    nvec++; if (cs_n !== 1'b1 || eng_start !== 1'b0) begin nerr++; $display("FAIL idle_no_req: got cs_n=%b start=%b want 1/0", cs_n, eng_start); end
  endtask

  task automatic test_tie();
    bit ok;
    a_bytes[0] = 8'h11; b_bytes[0] = 8'h22; ia.len = 4'd0; ib.len = 4'd0;
    // first tie after reset
    ia.req = 1'b1; ib.req = 1'b1;
    wait_for(4, 20, ok);
    nvec++; if ({ia.gnt, ib.gnt} !== 2'b10) begin nerr++; $display("FAIL tie1_grant: got a/b=%b want 10", {ia.gnt, ib.gnt}); end
    ia.req = 1'b0;
    wait_for(3, 60, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL tie1_b_next: got no b_gnt want b_gnt"); end
    ib.req = 1'b0;
    wait_for(1, 60, ok);
    repeat (8) tick();
    // B was last: tie goes to A
    ia.req = 1'b1; ib.req = 1'b1;
    wait_for(4, 20, ok);
    nvec++; if ({ia.gnt, ib.gnt} !== 2'b10) begin nerr++; $display("FAIL tie2_grant: got a/b=%b want 10", {ia.gnt, ib.gnt}); end
    ia.req = 1'b0; ib.req = 1'b0;
    wait_for(0, 60, ok);
    repeat (8) tick();
    // A was last: tie goes to B
    ia.req = 1'b1; ib.req = 1'b1;
    wait_for(4, 20, ok);
    nvec++; if ({ia.gnt, ib.gnt} !== 2'b01) begin nerr++; $display("FAIL tie3_grant: got a/b=%b want 01", {ia.gnt, ib.gnt}); end
    ia.req = 1'b0; ib.req = 1'b0;
    wait_for(1, 60, ok);
    repeat (8) tick();
  endtask

  task automatic test_single_a();
    bit ok;
    do_clr();
    busy_len = 3; a_bytes[0] = 8'hA5; ia.len = 4'd0; ia.req = 1'b1;
    wait_for(2, 20, ok);
    ia.req = 1'b0;
    nvec++; if (!ok) begin nerr++; $display("FAIL single_gnt: got no a_gnt want a_gnt"); end
    wait_for(0, 100, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL single_done: got timeout want a_done"); end
    nvec++; if (n_start != 1 || qat(st_din, 0) !== 8'hA5) begin
      nerr++; $display("FAIL single_start: got %0d starts din=%h want 1 / a5", n_start, qat(st_din, 0)); end
    nvec++; if (a_rxv != 1 || qat(a_rx, 0) !== 8'hA5) begin
      nerr++; $display("FAIL single_rx: got %0d rx_valid data=%h want 1 / a5", a_rxv, qat(a_rx, 0)); end
    nvec++; if (a_done != 1 || a_ack != 1) begin nerr++; $display("FAIL single_counts: got done=%0d ack=%0d want 1/1", a_done, a_ack); end
    nvec++; if (cs_bad != 0) begin nerr++; $display("FAIL single_cs_low: got %0d cs_n-high cycles want 0", cs_bad); end
    nvec++; if (b_ack + b_rxv + b_done != 0 || xtalk != 0) begin
      nerr++; $display("FAIL single_b_quiet: got b events=%0d xtalk=%0d want 0/0", b_ack + b_rxv + b_done, xtalk); end
    nvec++; if (lat_last != 7) begin nerr++; $display("FAIL single_latency: got %0d want 7", lat_last); end
    repeat (8) tick();
  endtask

  task automatic test_multi_b();
    bit ok;
    do_clr();
    for (int i = 0; i < 4; i++) b_bytes[i] = 8'(i + 1);
    ib.len = 4'd3; ib.req = 1'b1;
    wait_for(3, 20, ok);
    ib.req = 1'b0;
    wait_for(1, 200, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL multi_done: got timeout want b_done"); end
    nvec++; if (ib.rx_valid !== 1'b1 || ib.rx_data !== 8'h04) begin
      nerr++; $display("FAIL multi_done_last: got rxv=%b data=%h want 1/04", ib.rx_valid, ib.rx_data); end
    nvec++; if (b_ack != 4 || b_rxv != 4 || b_done != 1 || n_start != 4) begin
      nerr++; $display("FAIL multi_counts: got ack=%0d rxv=%0d done=%0d start=%0d want 4/4/1/4", b_ack, b_rxv, b_done, n_start); end
    for (int i = 0; i < 4; i++) begin
      nvec++; if (qat(b_rx, i) !== 8'(i + 1) || qat(st_din, i) !== 8'(i + 1)) begin
        nerr++; $display("FAIL multi_byte%0d: got rx=%h din=%h want %h", i, qat(b_rx, i), qat(st_din, i), 8'(i + 1)); end
    end
    nvec++; if (cs_bad != 0 || xtalk != 0 || a_ack + a_rxv + a_done != 0) begin
      nerr++; $display("FAIL multi_cs_iso: got cs_bad=%0d xtalk=%0d a_ev=%0d want 0/0/0", cs_bad, xtalk, a_ack + a_rxv + a_done); end
    tick();
    nvec++; if (ib.gnt !== 1'b0 || cs_n !== 1'b1) begin nerr++; $display("FAIL multi_release: got gnt=%b cs_n=%b want 0/1", ib.gnt, cs_n); end
    repeat (8) tick();
  endtask

  task automatic test_gap();
    bit ok;
    int hi, exp_hi;
`ifdef AS512512512_SPI_CS_GAP_EN
    exp_hi = CS_GAP;
`else
    exp_hi = 1;
`endif
    do_clr();
    a_bytes[0] = 8'h5A; b_bytes[0] = 8'hC3; ia.len = 4'd0; ib.len = 4'd0;
    ia.req = 1'b1;
    wait_for(2, 20, ok);
    ia.req = 1'b0; ib.req = 1'b1;
    wait_for(0, 100, ok);
    hi = 0; ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ib.gnt) begin ok = 1'b1; break; end
      if (cs_n) hi++;
    end
    ib.req = 1'b0;
    nvec++; if (!ok) begin nerr++; $display("FAIL gap_b_gnt: got timeout want b_gnt"); end
    nvec++; if (hi != exp_hi) begin nerr++; $display("FAIL gap_cs_high: got %0d cycles want %0d", hi, exp_hi); end
    nvec++; if (cs_n !== 1'b0) begin nerr++; $display("FAIL gap_cs_at_gnt: got %b want 0", cs_n); end
    wait_for(1, 100, ok);
    nvec++; if (qat(b_rx, 0) !== 8'hC3) begin nerr++; $display("FAIL gap_b_rx: got %h want c3", qat(b_rx, 0)); end
    repeat (8) tick();
  endtask

  task automatic test_long_busy();
    bit ok;
    do_clr();
    divisor = 8'd99; busy_len = 200; a_bytes[0] = 8'h3C; ia.len = 4'd0; ia.req = 1'b1;
    wait_for(2, 20, ok);
    ia.req = 1'b0;
    nvec++; if (eng_divisor !== 8'd99) begin nerr++; $display("FAIL long_divisor: got %0d want 99", eng_divisor); end
    wait_for(0, 400, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL long_done: got timeout want a_done"); end
    nvec++; if (n_start != 1 || busy_rxv != 0) begin
      nerr++; $display("FAIL long_starts: got start=%0d rxv_while_busy=%0d want 1/0", n_start, busy_rxv); end
    nvec++; if (lat_last != 204 || qat(a_rx, 0) !== 8'h3C) begin
      nerr++; $display("FAIL long_latency: got %0d data=%h want 204 / 3c", lat_last, qat(a_rx, 0)); end
    busy_len = 3; divisor = 8'd4;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_clr();
    a_bytes[0] = 8'h10; a_bytes[1] = 8'h20; a_bytes[2] = 8'h30; a_bytes[3] = 8'h40;
    ia.len = 4'd3; ia.req = 1'b1;
    wait_for(2, 20, ok);
    ia.req = 1'b0;
    wait_for(5, 100, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL rmid_byte2: got timeout want second tx_ack"); end
    tick();
    rst_n = 1'b0;
    tick();
    nvec++; if (cs_n !== 1'b1 || ia.gnt !== 1'b0 || eng_start !== 1'b0) begin
      nerr++; $display("FAIL rmid_abort: got cs_n=%b gnt=%b start=%b want 1/0/0", cs_n, ia.gnt, eng_start); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    nvec++; if (a_done != 0 || a_rxv != 1 || cs_n !== 1'b1) begin
      nerr++; $display("FAIL rmid_no_done: got done=%0d rxv=%0d cs_n=%b want 0/1/1", a_done, a_rxv, cs_n); end
    do_clr();
    ia.len = 4'd0; ia.req = 1'b1;
    wait_for(6, 20, ok);
    ia.req = 1'b0;
    nvec++; if (!ok || eng_start !== 1'b0 || ia.gnt !== 1'b1) begin
      nerr++; $display("FAIL rmid_setup: got cs_low=%b start=%b gnt=%b want 1/0/1", ok, eng_start, ia.gnt); end
    tick();
    nvec++; if (eng_start !== 1'b1 || eng_din !== 8'h10) begin
      nerr++; $display("FAIL rmid_load: got start=%b din=%h want 1/10", eng_start, eng_din); end
    wait_for(0, 100, ok);
    nvec++; if (!ok || qat(a_rx, 0) !== 8'h10) begin
      nerr++; $display("FAIL rmid_restart: got done=%b rx=%h want 1/10", ok, qat(a_rx, 0)); end
    repeat (4) tick();
  endtask

  initial begin
    ia.req = 1'b0; ib.req = 1'b0; ia.len = '0; ib.len = '0;
    for (int i = 0; i < 16; i++) begin a_bytes[i] = '0; b_bytes[i] = '0; end
    test_reset();
    test_tie();
    test_single_a();
    test_multi_b();
    test_gap();
    test_long_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
